// File: rtl/mq_pkg.sv
// Shared definitions for the multi-queue FIFO: width helpers and the request record.
package mq_pkg;

  localparam int MQ_MAX_QW    = 8;
  localparam int MQ_MAX_WIDTH = 64;

  // Request record sized for the widest supported configuration.
  typedef struct packed {
    logic                    valid;
    logic [MQ_MAX_QW-1:0]    qid;
    logic [MQ_MAX_WIDTH-1:0] data;
  } mq_req_t;

  function automatic int mq_qid_width(input int numQ);
    return (numQ > 1) ? $clog2(numQ) : 1;
  endfunction

  function automatic int mq_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int mq_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mq_lane.sv
// One circular FIFO lane: storage, read/write pointers and occupancy count.
module mq_lane
  import mq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CW    = mq_count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = mq_ptr_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= nextPtr(r_wptr);
      if (i_pop)  r_rptr <= nextPtr(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !reset) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/multi_queue_fifo.sv
// Bank of NUM_Q independent FIFOs behind one shared push port and one shared pop port.
module multi_queue_fifo
  import mq_pkg::*;
#(
  parameter  int NUM_Q = 3,
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int QW    = mq_qid_width(NUM_Q),
  localparam int CW    = mq_count_width(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_valid,
  input  logic [QW-1:0]       push_qid,
  input  logic [WIDTH-1:0]    push_data,
  output logic                push_ready,
  input  logic                pop_req,
  input  logic [QW-1:0]       pop_qid,
  output logic                pop_valid,
  output logic [WIDTH-1:0]    pop_data,
  output logic [NUM_Q*CW-1:0] q_count,
  output logic [NUM_Q-1:0]    q_empty,
  output logic [NUM_Q-1:0]    q_full,
  output logic                err
);

  logic [NUM_Q-1:0] w_pushEn;
  logic [NUM_Q-1:0] w_popEn;
  logic [NUM_Q-1:0] w_full;
  logic [NUM_Q-1:0] w_empty;
  logic [WIDTH-1:0] w_head [NUM_Q];
  logic [CW-1:0]    w_count [NUM_Q];
  logic             w_pushReady;
  logic             w_popAccept;
  logic [WIDTH-1:0] w_popHead;

  logic             r_popValid;
  logic [WIDTH-1:0] r_popData;
  logic             r_err;

  // Out-of-range qids match no lane, so they are neither ready nor accepted.
  always_comb begin
    w_pushEn    = '0;
    w_popEn     = '0;
    w_pushReady = 1'b0;
    w_popAccept = 1'b0;
    w_popHead   = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (push_qid == QW'(i) && !w_full[i]) begin
        w_pushReady = 1'b1;
        w_pushEn[i] = push_valid;
      end
      if (pop_qid == QW'(i) && !w_empty[i]) begin
        w_popAccept = pop_req;
        w_popEn[i]  = pop_req;
        w_popHead   = w_head[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_popValid <= 1'b0;
      r_popData  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_popValid <= w_popAccept;
      if (w_popAccept) r_popData <= w_popHead;
      r_err <= (push_valid && !w_pushReady) || (pop_req && !w_popAccept);
    end
  end

  for (genvar g = 0; g < NUM_Q; g++) begin : g_lane
    mq_lane #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .CW    (CW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_pushEn[g]),
      .i_pop   (w_popEn[g]),
      .i_data  (push_data),
      .o_head  (w_head[g]),
      .o_count (w_count[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
    assign q_count[g*CW +: CW] = w_count[g];
  end

  assign push_ready = w_pushReady;
  assign pop_valid  = r_popValid;
  assign pop_data   = r_popData;
  assign q_empty    = w_empty;
  assign q_full     = w_full;
  assign err        = r_err;

endmodule
